div_unit: RTL

- Multi-cycle radix-2 restoring divider in the EX stage. Consumes the 5-bit ALU control code from the ALU decoder and services DIV/DIVU. All other codes go to the single-cycle ALU.
- Produces a 64-bit {remainder, quotient} result for the HI/LO register write.
- Stalls the pipeline while a division is in flight. Honours flush/annul from the exception logic.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_iter.sv | 22 ++
 rtl/div_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared ALU control codes and divider FSM state encodings for the EX stage.
// No logic of its own; latency and backpressure are defined by the users.
package div_unit_pkg;

   localparam logic [4:0] ADD_CONTROL  = 5'b00010;
   localparam logic [4:0] DIV_CONTROL  = 5'b10110;
   localparam logic [4:0] DIVU_CONTROL = 5'b10111;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_BYZERO = 2'b01;
   localparam logic [1:0] ST_ON     = 2'b10;
   localparam logic [1:0] ST_END    = 2'b11;

   function automatic logic is_div_code(input logic [4:0] code);
      return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
   endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift partial left, trial-subtract divisor, keep or restore.
// Purely combinational (0 cycles); no flow control.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] i_part,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [2*WIDTH:0] o_part
);

   logic [WIDTH+1:0] w_hi;
   logic [WIDTH+1:0] w_diff;
   logic             w_ge;

   // Upper bits already shifted by one; the extra top bit keeps the trial sign unambiguous.
   assign w_hi   = i_part[2*WIDTH:WIDTH-1];
   assign w_diff = w_hi - {2'b00, i_divisor};
   assign w_ge   = ~w_diff[WIDTH+1];

   assign o_part = {(w_ge ? w_diff[WIDTH:0] : w_hi[WIDTH:0]), i_part[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU: ready WIDTH+1 cycles after request (2 for /0).
// Holds combinational stall high while a division is in flight; annul aborts to IDLE.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [4:0]         alucontrol,
   input  logic               valid,
   input  logic               annul,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH:0]   r_part;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [2*WIDTH-1:0] r_result;

   logic [1:0]         w_state_nxt;
   logic               w_req;
   logic               w_signed;
   logic               w_div_nz;
   logic               w_last;
   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [2*WIDTH:0]   w_next;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_req    = valid & ~annul & is_div_code(alucontrol);
   assign w_signed = (alucontrol == DIV_CONTROL);
   assign w_div_nz = |opdata2;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
   assign w_abs1 = (w_signed & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
   assign w_abs2 = (w_signed & opdata2[WIDTH-1]) ? -opdata2 : opdata2;

   div_iter #(
      .WIDTH (WIDTH)
   ) u_div_iter (
      .i_part    (r_part),
      .i_divisor (r_divisor),
      .o_part    (w_next)
   );

   assign w_quo_fix = r_neg_q ? -w_next[WIDTH-1:0]       : w_next[WIDTH-1:0];
   assign w_rem_fix = r_neg_r ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];

   assign ready  = (r_state == ST_END) & ~annul;
   assign stall  = w_req & ~ready;
   assign result = r_result;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_state_nxt = w_div_nz ? ST_ON : ST_BYZERO;
            end
         end
         ST_ON: begin
            if (w_last) begin
               w_state_nxt = ST_END;
            end
         end
         ST_BYZERO: w_state_nxt = ST_END;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (annul) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_part    <= '0;
         r_divisor <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_result  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_req && w_div_nz) begin
            r_part    <= {{(WIDTH + 1){1'b0}}, w_abs1};
            r_divisor <= w_abs2;
            r_neg_q   <= w_signed & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_r   <= w_signed & opdata1[WIDTH-1];
            r_cnt     <= '0;
         end
         if ((r_state == ST_ON) && !annul) begin
            r_part <= w_next;
            r_cnt  <= r_cnt + CW'(1);
         end
         // Result is latched on entry to END so it is stable for the whole ready cycle.
         if ((r_state == ST_ON) && (w_state_nxt == ST_END)) begin
            r_result <= {w_rem_fix, w_quo_fix};
         end
         if ((r_state == ST_BYZERO) && (w_state_nxt == ST_END)) begin
            r_result <= '0;
         end
      end
   end

endmodule
